// File: rtl/fp_addsub_serial_pkg.sv
// Shared definitions for the digit-serial Fp add/sub engine and its controller.
// Op encoding and FSM state enum are exported here for reuse.
package fp_addsub_serial_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Digit counter width; at least one bit even for single-digit operands.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_addsub_serial_unit_adder.sv
// Combinational W-bit adder with carry in and carry out.
module fp_addsub_serial_unit_adder #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum_c,
    output logic         cout_c
);

    logic [W:0] full;

    assign full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum_c  = full[W-1:0];
    assign cout_c = full[W];

endmodule

// File: rtl/fp_addsub_serial.sv
// Digit-serial add/subtract engine, LSB digit first, ready/valid on both streams.
// Optional zero-detect on the result is enabled by defining FP_ADDSUB_ZERO_FLAG_EN.
module fp_addsub_serial
    import fp_addsub_serial_pkg::*;
#(
    parameter int unsigned RADIX  = 32,
    parameter int unsigned DIGITS = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic             carry_in,
    output logic             busy,
    input  logic             digit_in_valid,
    output logic             digit_in_ready,
    input  logic [RADIX-1:0] digit_a,
    input  logic [RADIX-1:0] digit_b,
    output logic             digit_out_valid,
    input  logic             digit_out_ready,
    output logic [RADIX-1:0] digit_res,
    output logic             digit_last,
    output logic             done,
    output logic             carry_out,
    output logic             res_zero
);

    localparam int unsigned     CNT_W    = cnt_width(DIGITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

    state_e           state_q, state_d;
    logic             op_sub_q, op_sub_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             dov_q, dov_d;
    logic [RADIX-1:0] res_q, res_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             carry_out_q, carry_out_d;

    logic [RADIX-1:0] b_eff;
    logic [RADIX-1:0] sum;
    logic             cout;
    logic             start_acc;
    logic             in_xfer;
    logic             out_xfer;
    logic             is_last;

    // Subtraction is A + ~B + ~borrow_in through the same adder.
    assign b_eff = (op_sub_q == OP_SUB) ? ~digit_b : digit_b;

    fp_addsub_serial_unit_adder #(.W(RADIX)) u_unit_adder (
        .a      (digit_a),
        .b      (b_eff),
        .cin    (c_q),
        .sum_c  (sum),
        .cout_c (cout)
    );

    assign digit_in_ready = (state_q == RUN) & (~dov_q | digit_out_ready);
    assign start_acc      = (state_q == IDLE) & start;
    assign in_xfer        = digit_in_valid & digit_in_ready;
    assign out_xfer       = dov_q & digit_out_ready;
    assign is_last        = (cnt_q == LAST_IDX);

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        op_sub_d    = op_sub_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        dov_d       = dov_q;
        res_d       = res_q;
        last_d      = last_q;
        done_d      = 1'b0;
        carry_out_d = carry_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_sub_d = op_sub;
                    c_d      = (op_sub == OP_SUB) ? ~carry_in : carry_in;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (in_xfer) begin
                    c_d    = cout;
                    res_d  = sum;
                    dov_d  = 1'b1;
                    last_d = is_last;
                    if (is_last) begin
                        carry_out_d = (op_sub_q == OP_SUB) ? ~cout : cout;
                        state_d     = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (out_xfer) begin
                    dov_d = 1'b0;
                end
            end
            DRAIN: begin
                if (out_xfer) begin
                    dov_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_sub_q    <= OP_ADD;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            dov_q       <= 1'b0;
            res_q       <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_sub_q    <= op_sub_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            dov_q       <= dov_d;
            res_q       <= res_d;
            last_q      <= last_d;
            done_q      <= done_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign busy            = busy_q;
    assign digit_out_valid = dov_q;
    assign digit_res       = res_q;
    assign digit_last      = last_q;
    assign done            = done_q;
    assign carry_out       = carry_out_q;

`ifdef FP_ADDSUB_ZERO_FLAG_EN
    logic any_nz_q, any_nz_d;
    logic res_zero_q, res_zero_d;

    // Sticky OR of result digits; flag latched alongside carry_out.
    always_comb begin
        any_nz_d   = any_nz_q;
        res_zero_d = res_zero_q;
        if (start_acc) begin
            any_nz_d = 1'b0;
        end else if (in_xfer) begin
            any_nz_d = any_nz_q | (|sum);
            if (is_last) begin
                res_zero_d = ~(any_nz_q | (|sum));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_nz_q   <= 1'b0;
            res_zero_q <= 1'b0;
        end else begin
            any_nz_q   <= any_nz_d;
            res_zero_q <= res_zero_d;
        end
    end

    assign res_zero = res_zero_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign res_zero         = 1'b0;
`endif

endmodule

// File: tb/tb_fp_addsub_serial.sv
// Scoreboard bench for fp_addsub_serial at RADIX=8, DIGITS=2.
module tb_fp_addsub_serial;

    localparam int unsigned RADIX  = 8;
    localparam int unsigned DIGITS = 2;

`ifdef FP_ADDSUB_ZERO_FLAG_EN
    localparam logic ZF_EN = 1'b1;
`else
    localparam logic ZF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             op_sub;
    logic             carry_in;
    logic             busy;
    logic             digit_in_valid;
    logic             digit_in_ready;
    logic [RADIX-1:0] digit_a;
    logic [RADIX-1:0] digit_b;
    logic             digit_out_valid;
    logic             digit_out_ready;
    logic [RADIX-1:0] digit_res;
    logic             digit_last;
    logic             done;
    logic             carry_out;
    logic             res_zero;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    logic [8:0] sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_addsub_serial #(.RADIX(RADIX), .DIGITS(DIGITS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .op_sub          (op_sub),
        .carry_in        (carry_in),
        .busy            (busy),
        .digit_in_valid  (digit_in_valid),
        .digit_in_ready  (digit_in_ready),
        .digit_a         (digit_a),
        .digit_b         (digit_b),
        .digit_out_valid (digit_out_valid),
        .digit_out_ready (digit_out_ready),
        .digit_res       (digit_res),
        .digit_last      (digit_last),
        .done            (done),
        .carry_out       (carry_out),
        .res_zero        (res_zero)
    );

    // One complete operation; called at a negedge, returns at the negedge where done is seen.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic cin, input int stall, input logic poke,
                          input logic [15:0] exp_res, input logic exp_carry,
                          input logic exp_zero, input logic chk_lat, input string name);
        int sent;
        int recv;
        int stall_left;
        int budget;
        int unsigned t0;
        logic [7:0] held;
        logic held_v;
        logic in_x;
        logic out_x;
        logic fin;
        logic [8:0] exp_d;

        sb_q.push_back({1'b0, exp_res[7:0]});
        sb_q.push_back({1'b1, exp_res[15:8]});

        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_before_start got=%b exp=0", name, busy);
        end
        start           = 1'b1;
        op_sub          = sub;
        carry_in        = cin;
        digit_in_valid  = 1'b0;
        digit_out_ready = 1'b1;
        t0              = cyc;
        @(negedge clk);
        start    = 1'b0;
        op_sub   = 1'($urandom);
        carry_in = 1'($urandom);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_done_after_start got=%b%b exp=10", name, busy, done);
        end

        sent = 0; recv = 0; stall_left = stall; held_v = 1'b0; budget = 0; fin = 1'b0;
        held = '0;
        while (!fin && budget < 40) begin
            digit_in_valid = (sent < 2);
            if (sent < 2) begin
                digit_a = a[8*sent +: 8];
                digit_b = b[8*sent +: 8];
            end else begin
                digit_a = 8'($urandom);
                digit_b = 8'($urandom);
            end
            digit_out_ready = 1'b1;
            if (stall_left > 0 && digit_out_valid && recv == 0) begin
                digit_out_ready = 1'b0;
                stall_left--;
            end
            start = poke && (sent == 1);
            #1;
            in_x  = digit_in_valid & digit_in_ready;
            out_x = digit_out_valid & digit_out_ready;
            if (budget == 0) begin
                total++;
                if (digit_in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL %s ready_after_start got=%b exp=1", name, digit_in_ready);
                end
            end
            if (digit_out_valid && !digit_out_ready) begin
                total++;
                if (digit_in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s ready_in_stall got=%b exp=0", name, digit_in_ready);
                end
                if (held_v) begin
                    total++;
                    if (digit_res !== held) begin
                        bad++;
                        $display("FAIL %s res_hold got=%h exp=%h", name, digit_res, held);
                    end
                end
                held   = digit_res;
                held_v = 1'b1;
            end
            if (out_x) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_digit got=%h exp=none", name, digit_res);
                end else begin
                    exp_d = sb_q.pop_front();
                    if ({digit_last, digit_res} !== exp_d) begin
                        bad++;
                        $display("FAIL %s digit%0d got=%b/%h exp=%b/%h", name, recv,
                                 digit_last, digit_res, exp_d[8], exp_d[7:0]);
                    end
                end
                recv++;
            end
            if (in_x) sent++;
            @(negedge clk);
            start = 1'b0;
            budget++;
            fin = done;
        end
        digit_in_valid = 1'b0;

        total++;
        if (!fin) begin
            bad++;
            $display("FAIL %s done_timeout got=0 exp=1", name);
        end
        total++;
        if (carry_out !== exp_carry) begin
            bad++;
            $display("FAIL %s carry_out got=%b exp=%b", name, carry_out, exp_carry);
        end
        total++;
        if (res_zero !== exp_zero) begin
            bad++;
            $display("FAIL %s res_zero got=%b exp=%b", name, res_zero, exp_zero);
        end
        total++;
        if (recv != 2 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s digit_count got=%0d exp=2", name, recv);
            sb_q.delete();
        end
        if (chk_lat) begin
            total++;
            if (cyc - t0 != 4) begin
                bad++;
                $display("FAIL %s latency got=%0d exp=4", name, cyc - t0);
            end
        end
    endtask

    task automatic check_reset_vals(input string name);
        total++;
        if ({busy, digit_in_ready, digit_out_valid, digit_res, digit_last, done,
             carry_out, res_zero} !== 15'h0) begin
            bad++;
            $display("FAIL %s reset_outputs got=%b%b%b_%h_%b%b%b%b exp=all0", name, busy,
                     digit_in_ready, digit_out_valid, digit_res, digit_last, done,
                     carry_out, res_zero);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; op_sub = 1'b0; carry_in = 1'b0;
        digit_in_valid = 1'b0; digit_out_ready = 1'b1;
        digit_a = '0; digit_b = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset_low");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_released");
    endtask

    task automatic test_add();
        run_op(16'h01FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b1, "add");
        @(negedge clk);
    endtask

    task automatic test_sub();
        run_op(16'h0100, 16'h0001, 1'b1, 1'b0, 0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b1, "sub");
        @(negedge clk);
    endtask

    task automatic test_sub_underflow();
        run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, "sub_uf");
        @(negedge clk);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, "sub_uf_bin");
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        run_op(16'h01FF, 16'h0001, 1'b0, 1'b0, 3, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0, "bp_add");
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic saw_done;
        start = 1'b1; op_sub = 1'b0; carry_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        digit_in_valid = 1'b1; digit_a = 8'hFF; digit_b = 8'h01; digit_out_ready = 1'b1;
        @(negedge clk);
        digit_in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals("mid_op_reset");
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_op_no_done got=%b exp=0", saw_done);
        end
        sb_q.delete();
        run_op(16'h01FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b1, "after_reset");
        @(negedge clk);
    endtask

    task automatic test_zero_flag();
        run_op(16'h1234, 16'h1234, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 1'b0, ZF_EN, 1'b0, "zero_flag");
        @(negedge clk);
    endtask

    // Each op starts in the done cycle of the previous; some poke start while busy.
    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        logic sub;
        logic cin;
        logic [16:0] full;
        run_op(16'h0100, 16'h0001, 1'b1, 1'b0, 0, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1, "b2b_sub");
        run_op(16'h01FF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b1, "b2b_add");
        for (int i = 0; i < 8; i++) begin
            a   = 16'($urandom);
            b   = (i == 3) ? a : 16'($urandom);
            sub = (i % 2 == 1);
            cin = 1'($urandom);
            if (sub) full = {1'b0, a} - {1'b0, b} - {16'h0, cin};
            else     full = {1'b0, a} + {1'b0, b} + {16'h0, cin};
            run_op(a, b, sub, cin, i % 3, 1'b0, full[15:0], full[16],
                   ZF_EN & (full[15:0] == 16'h0), 1'b0, "b2b_rand");
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got=%b%b exp=00", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_sub_underflow();
        test_backpressure();
        test_reset_mid_op();
        test_zero_flag();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
